eco_sweep_arb: RTL and testbench

Controller that time-shares one 4-bit combinational function unit (the gate-level a/b → y netlist under ECO) between two operand requesters. It also contains an exhaustive-sweep engine that drives all 256 (a,b) pairs through the unit and folds the results into an 8-bit signature. Golden and revised netlists can then be compared by signature. It sits between the ECO test stimulus logic and the function-unit instance, which it drives through registered operand outputs.

---
 rtl/eco_sweep_arb_pkg.sv | 26 ++
 rtl/eco_sweep_arb_if.sv | 37 +++
 rtl/eco_rr_arb2.sv | 43 ++++
 rtl/eco_sweep_arb.sv | 136 +++++++++++++
 tb/tb_eco_sweep_arb.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/eco_sweep_arb_pkg.sv
// Shared types and constants for the eco_sweep_arb block: FSM states, stage tag kinds,
// sweep length, signature width and the signature fold helper.
package eco_pkg;

    localparam int SWEEP_LEN = 256;
    localparam int SIG_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        REQ = 1'b0,
        SWP = 1'b1
    } kind_e;

    // Rotate-left by one, then fold the 4-bit result into the low nibble.
    function automatic logic [SIG_W-1:0] sigFold(input logic [SIG_W-1:0] sig,
                                                 input logic [3:0]       y);
        return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ {{(SIG_W-4){1'b0}}, y};
    endfunction

endpackage

// File: rtl/eco_sweep_arb_if.sv
// Bundle of requester handshakes, function-unit operands/result, response and sweep
// control signals; slave is the controller's view, master the stimulus side.
interface eco_sweep_arb_if;
    import eco_pkg::*;

    logic             r0_valid;
    logic             r0_ready;
    logic [3:0]       r0_a;
    logic [3:0]       r0_b;
    logic             r1_valid;
    logic             r1_ready;
    logic [3:0]       r1_a;
    logic [3:0]       r1_b;
    logic [3:0]       fu_a;
    logic [3:0]       fu_b;
    logic [3:0]       fu_y;
    logic             rsp_valid;
    logic             rsp_id;
    logic [3:0]       rsp_y;
    logic             sweep_start;
    logic             sweep_busy;
    logic             sweep_done;
    logic [SIG_W-1:0] sweep_sig;

    modport slave (
        input  r0_valid, r0_a, r0_b, r1_valid, r1_a, r1_b, fu_y, sweep_start,
        output r0_ready, r1_ready, fu_a, fu_b, rsp_valid, rsp_id, rsp_y,
               sweep_busy, sweep_done, sweep_sig
    );

    modport master (
        output r0_valid, r0_a, r0_b, r1_valid, r1_a, r1_b, fu_y, sweep_start,
        input  r0_ready, r1_ready, fu_a, fu_b, rsp_valid, rsp_id, rsp_y,
               sweep_busy, sweep_done, sweep_sig
    );

endinterface

// File: rtl/eco_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from a valid vector, holding the id of
// the last winner so a tie goes to the other requester.
module eco_rr_arb2
    import eco_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;
    logic [1:0] grant;

    always_comb begin
        grant = 2'b00;
        if (enable_i) begin
            if (valid_i == 2'b11) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = valid_i;
            end
        end
        last_d = last_q;
        if (|grant) begin
            last_d = grant[1];
        end
    end

    // Starting at 1 makes requester 0 win the very first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign grant_o = grant;

endmodule

// File: rtl/eco_sweep_arb.sv
// Time-shares one 4-bit function unit between two requesters and, when ECO_SWEEP_EN is
// defined, runs an exhaustive 256-pair sweep folding results into a signature.
module eco_sweep_arb
    import eco_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    eco_sweep_arb_if.slave bus
);

    logic [1:0] reqVec;
    logic [1:0] grant;
    logic       arbEn;
    logic       xfer;
    logic       xferId;

    logic [3:0] fuA_q;
    logic [3:0] fuB_q;
    logic       s1Valid_q;
    logic       s1Id_q;
    kind_e      s1Kind_q;
    logic       rspValid_q;
    logic       rspId_q;
    logic [3:0] rspY_q;

`ifdef ECO_SWEEP_EN
    state_e           state_q;
    logic [7:0]       cnt_q;
    logic [SIG_W-1:0] sig_q;

    assign arbEn = (state_q == IDLE) && !rst;
`else
    logic unusedStart;

    assign unusedStart = bus.sweep_start;
    assign arbEn       = !rst;
`endif

    assign reqVec = {bus.r1_valid, bus.r0_valid};

    eco_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (reqVec),
        .enable_i (arbEn),
        .grant_o  (grant)
    );

    assign xfer   = |grant;
    assign xferId = grant[1];

    // Stage 1 latches operands, stage 2 captures the unit's result one edge later;
    // sweep issue overrides stage 1 while the FSM is outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            fuA_q      <= '0;
            fuB_q      <= '0;
            s1Valid_q  <= 1'b0;
            s1Id_q     <= 1'b0;
            s1Kind_q   <= REQ;
            rspValid_q <= 1'b0;
            rspId_q    <= 1'b0;
            rspY_q     <= '0;
`ifdef ECO_SWEEP_EN
            state_q    <= IDLE;
            cnt_q      <= '0;
            sig_q      <= '0;
`endif
        end else begin
            rspValid_q <= s1Valid_q && (s1Kind_q == REQ);
            if (s1Valid_q && (s1Kind_q == REQ)) begin
                rspY_q  <= bus.fu_y;
                rspId_q <= s1Id_q;
            end

            s1Valid_q <= xfer;
            if (xfer) begin
                fuA_q    <= xferId ? bus.r1_a : bus.r0_a;
                fuB_q    <= xferId ? bus.r1_b : bus.r0_b;
                s1Id_q   <= xferId;
                s1Kind_q <= REQ;
            end

`ifdef ECO_SWEEP_EN
            if (s1Valid_q && (s1Kind_q == SWP)) begin
                sig_q <= sigFold(sig_q, bus.fu_y);
            end

            case (state_q)
                IDLE: begin
                    if (bus.sweep_start) begin
                        state_q <= SWEEP;
                        cnt_q   <= '0;
                        sig_q   <= '0;
                    end
                end
                SWEEP: begin
                    fuA_q     <= cnt_q[7:4];
                    fuB_q     <= cnt_q[3:0];
                    s1Valid_q <= 1'b1;
                    s1Kind_q  <= SWP;
                    cnt_q     <= cnt_q + 8'd1;
                    if (cnt_q == 8'(SWEEP_LEN - 1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
`endif
        end
    end

    assign bus.r0_ready  = grant[0];
    assign bus.r1_ready  = grant[1];
    assign bus.fu_a      = fuA_q;
    assign bus.fu_b      = fuB_q;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_id    = rspId_q;
    assign bus.rsp_y     = rspY_q;

`ifdef ECO_SWEEP_EN
    assign bus.sweep_busy = (state_q != IDLE);
    assign bus.sweep_done = (state_q == DONE);
    assign bus.sweep_sig  = sig_q;
`else
    assign bus.sweep_busy = 1'b0;
    assign bus.sweep_done = 1'b0;
    assign bus.sweep_sig  = '0;
`endif

endmodule

// File: tb/tb_eco_sweep_arb.sv
// Randomized self-checking bench for eco_sweep_arb against a cycle-level reference model;
// follows ECO_SWEEP_EN the same way the design does.
module tb_eco_sweep_arb;
    import eco_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   fuMode = 0;

    eco_sweep_arb_if bus ();

    eco_sweep_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef ECO_SWEEP_EN
    localparam bit SWEEP_ON = 1'b1;
`else
    localparam bit SWEEP_ON = 1'b0;
`endif

    function automatic logic [3:0] stubY(input logic [3:0] a, input logic [3:0] b, input int mode);
        case (mode)
            1:       return 4'h1;
            2:       return 4'(a + (b << 1) + 4'h3);
            default: return a ^ b;
        endcase
    endfunction

    assign bus.fu_y = stubY(bus.fu_a, bus.fu_b, fuMode);

    // Signature of a full sweep: every (a,b) pair in counting order, rotate-left then xor.
    function automatic logic [7:0] refSig(input int mode);
        int s = 0;
        for (int v = 0; v < SWEEP_LEN; v++) begin
            logic [3:0] y = stubY(4'(v / 16), 4'(v % 16), mode);
            s = (((s * 2) % 256) + (s / 128)) ^ int'(y);
        end
        return 8'(s);
    endfunction

    typedef struct {
        bit         v;
        bit         id;
        logic [3:0] y;
    } pend_t;

    int         checks = 0;
    int         errors = 0;
    bit         mLast = 1'b1;
    int         mBusy = 0;
    pend_t      p1 = '{0, 0, 4'h0};
    pend_t      p2 = '{0, 0, 4'h0};
    logic [7:0] expSig = 8'h00;
    logic [7:0] finSig = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check against the model, then advance the model
    // across the coming rising edge.
    task automatic applyStimulus(input bit r0v, input logic [3:0] a0, input logic [3:0] b0,
                                 input bit r1v, input logic [3:0] a1, input logic [3:0] b1,
                                 input bit start, input bit rstIn);
        bit g0, g1, idle;
        @(negedge clk);
        rst             = rstIn;
        bus.r0_valid    = r0v;
        bus.r0_a        = a0;
        bus.r0_b        = b0;
        bus.r1_valid    = r1v;
        bus.r1_a        = a1;
        bus.r1_b        = b1;
        bus.sweep_start = start;
        #1;
        idle = (mBusy == 0) && !rstIn;
        g0 = idle && r0v && (!r1v || mLast);
        g1 = idle && r1v && (!r0v || !mLast);
        checkOutput("r0_ready", 32'(bus.r0_ready), 32'(g0));
        checkOutput("r1_ready", 32'(bus.r1_ready), 32'(g1));
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(p2.v));
        if (p2.v) begin
            checkOutput("rsp_id", 32'(bus.rsp_id), 32'(p2.id));
            checkOutput("rsp_y", 32'(bus.rsp_y), 32'(p2.y));
        end
        checkOutput("sweep_busy", 32'(bus.sweep_busy), 32'(mBusy > 0));
        checkOutput("sweep_done", 32'(bus.sweep_done), 32'(mBusy == 1));
        if (mBusy == 1) checkOutput("sweep_sig_final", 32'(bus.sweep_sig), 32'(finSig));
        else if (mBusy == 0) checkOutput("sweep_sig_hold", 32'(bus.sweep_sig), 32'(expSig));

        if (rstIn) begin
            mLast  = 1'b1;
            mBusy  = 0;
            p1     = '{0, 0, 4'h0};
            p2     = '{0, 0, 4'h0};
            expSig = 8'h00;
        end else begin
            p2 = p1;
            p1.v  = g0 || g1;
            p1.id = g1;
            p1.y  = g1 ? stubY(a1, b1, fuMode) : stubY(a0, b0, fuMode);
            if (g0 || g1) mLast = g1;
            if (mBusy > 0) begin
                if (mBusy == 1) expSig = finSig;
                mBusy--;
            end else if (start && SWEEP_ON) begin
                mBusy  = SWEEP_LEN + 2;
                finSig = refSig(fuMode);
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0);
    endtask

    task automatic randomCycles(input int n, input int startOdds);
        for (int i = 0; i < n; i++)
            applyStimulus($urandom_range(1, 0) == 1, 4'($urandom), 4'($urandom),
                          $urandom_range(1, 0) == 1, 4'($urandom), 4'($urandom),
                          $urandom_range(startOdds, 0) == 0, 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.r0_valid    = 1'b0;
        bus.r0_a        = 4'h0;
        bus.r0_b        = 4'h0;
        bus.r1_valid    = 1'b0;
        bus.r1_a        = 4'h0;
        bus.r1_b        = 4'h0;
        bus.sweep_start = 1'b0;

        applyStimulus(1, 4'h9, 4'h2, 1, 4'h4, 4'h4, 1, 1);
        applyStimulus(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 1);
        idleCycles(1);
        checkOutput("reset_fu_a", 32'(bus.fu_a), 32'h0);
        checkOutput("reset_fu_b", 32'(bus.fu_b), 32'h0);
        checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
        checkOutput("reset_rsp_y", 32'(bus.rsp_y), 32'h0);

        applyStimulus(1, 4'h5, 4'h3, 0, 4'h0, 4'h0, 0, 0);
        idleCycles(3);

        for (int i = 0; i < 4; i++)
            applyStimulus(1, 4'($urandom), 4'($urandom), 1, 4'($urandom), 4'($urandom), 0, 0);
        idleCycles(3);

        randomCycles(300, 1000000);
        idleCycles(3);

        fuMode = 1;
        applyStimulus(0, 4'h0, 4'h0, 1, 4'h7, 4'h1, 1, 0);
        for (int i = 0; i < SWEEP_LEN + 6; i++)
            applyStimulus(0, 4'h0, 4'h0, 1, 4'h7, 4'h1, 0, 0);
        idleCycles(3);

        fuMode = 2;
        applyStimulus(1, 4'hA, 4'h6, 0, 4'h0, 4'h0, 1, 0);
        randomCycles(SWEEP_LEN + 10, 20);
        idleCycles(3);

        fuMode = 0;
        applyStimulus(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0);
        randomCycles(100, 30);
        applyStimulus(1, 4'h3, 4'h3, 1, 4'h1, 4'h2, 0, 1);
        idleCycles(1);
        checkOutput("midreset_rsp_y", 32'(bus.rsp_y), 32'h0);
        checkOutput("midreset_sig", 32'(bus.sweep_sig), 32'h0);
        applyStimulus(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0);
        idleCycles(SWEEP_LEN + 4);

        randomCycles(400, 64);
        idleCycles(SWEEP_LEN + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
